dup_tx_serializer: RTL and testbench

DUP11 bit-oriented (HDLC/SDLC) transmitter serializer. It sits directly downstream of the TXDBUF register. It takes each character written into TXDBUF, adds opening flags, zero-bit stuffing, CRC-CCITT and closing flags or aborts, and shifts the result out one bit per modem clock enable. It returns the TXDONE handshake and the transmitter CRC LSB to the register file.

---
 rtl/dup_tx_pkg.sv | 25 ++
 rtl/dup_tx_serializer_if.sv | 22 ++
 rtl/dup_crc16.sv | 39 +++
 rtl/dup_tx_serializer.sv | 206 ++++++++++++++++++++
 tb/tb_dup_tx_serializer.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/dup_tx_pkg.sv
// Shared types and constants for the DUP11 bit-oriented transmitter/receiver.
package dup_tx_pkg;

    localparam int unsigned DATAW    = 8;
    localparam int unsigned CRCW     = 16;
    localparam int unsigned BITCNTW  = 4;
    localparam int unsigned ONESW    = 3;
    localparam int unsigned STUFFRUN = 5;

    localparam logic [DATAW-1:0] FLAGCHAR  = 8'h7E;
    localparam logic [DATAW-1:0] ABORTCHAR = 8'hFF;

    localparam logic [CRCW-1:0] CRCPOLY_DEF   = 16'h8408;
    localparam logic [CRCW-1:0] CRCPRESET_DEF = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        FLAG,
        DATA,
        CRC,
        CLOSE,
        ABORT
    } txState_t;

endpackage

// File: rtl/dup_tx_serializer_if.sv
// TXDBUF register-file side of the transmit serializer.
interface dup_tx_serializer_if import dup_tx_pkg::*; ();

    logic             txLOAD;
    logic [DATAW-1:0] dupTXDAT;
    logic             dupTXSOM;
    logic             dupTXEOM;
    logic             dupTXABRT;
    logic             dupTXDONE;
    logic             dupTXCRC;

    modport master (
        output txLOAD, dupTXDAT, dupTXSOM, dupTXEOM, dupTXABRT,
        input  dupTXDONE, dupTXCRC
    );

    modport slave (
        input  txLOAD, dupTXDAT, dupTXSOM, dupTXEOM, dupTXABRT,
        output dupTXDONE, dupTXCRC
    );

endinterface

// File: rtl/dup_crc16.sv
// Bit-serial reflected CRC-16 with synchronous preset; shared by TX and RX.
module dup_crc16
    import dup_tx_pkg::*;
#(
    parameter logic [CRCW-1:0] POLY   = CRCPOLY_DEF,
    parameter logic [CRCW-1:0] PRESET = CRCPRESET_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            init,
    input  logic            enable,
    input  logic            dataBit,
    output logic [CRCW-1:0] crc
);

    logic [CRCW-1:0] crcNxt;
    logic            feedback;

    // LSB-first shift with conditional polynomial fold; preset wins over update
    always_comb begin
        crcNxt   = crc;
        feedback = crc[0] ^ dataBit;
        if (init) begin
            crcNxt = PRESET;
        end else if (enable) begin
            crcNxt = {1'b0, crc[CRCW-1:1]} ^ (feedback ? POLY : '0);
        end
    end

    // CRC register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= PRESET;
        end else begin
            crc <= crcNxt;
        end
    end

endmodule

// File: rtl/dup_tx_serializer.sv
// DUP11 HDLC/SDLC transmit serializer: flags, zero stuffing, CRC-CCITT, aborts.
module dup_tx_serializer
    import dup_tx_pkg::*;
#(
    parameter logic [CRCW-1:0] CRCPRESET = CRCPRESET_DEF,
    parameter logic [CRCW-1:0] CRCPOLY   = CRCPOLY_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dupINIT,
    input  logic                txENABLE,
    input  logic                txCLKEN,
    dup_tx_serializer_if.slave  txb,
    output logic                txSDO,
    output logic                txACTIVE,
    output logic                txUNDER
);

    txState_t            state, stateNxt;
    logic [DATAW-1:0]    shReg, shRegNxt;
    logic [BITCNTW-1:0]  bitCnt, bitCntNxt;
    logic [ONESW-1:0]    onesCnt, onesCntNxt;
    logic                sdoNxt, underNxt, activeNxt;
    logic                txDone, doneNxt;
    logic [DATAW-1:0]    pendDat, pendDatNxt;
    logic                pendSom, pendSomNxt;
    logic                pendEom, pendEomNxt;
    logic                pendAbrt, pendAbrtNxt;

    logic                crcPreset, crcEn, crcBit;
    logic [CRCW-1:0]     crcOut;
    logic                unitLast, stuffState, stuffNow, taken;
    logic [BITCNTW-1:0]  nextIdx;

    dup_crc16 #(
        .POLY   (CRCPOLY),
        .PRESET (CRCPRESET)
    ) u_crc (
        .clk     (clk),
        .rst     (rst),
        .init    (dupINIT | crcPreset),
        .enable  (crcEn),
        .dataBit (crcBit),
        .crc     (crcOut)
    );

    assign txb.dupTXDONE = txDone;
    assign txb.dupTXCRC  = crcOut[0];

    // Next-state, bit selection, stuffing and TXDBUF handshake
    always_comb begin
        stateNxt    = state;
        shRegNxt    = shReg;
        bitCntNxt   = bitCnt;
        onesCntNxt  = onesCnt;
        sdoNxt      = txSDO;
        underNxt    = 1'b0;
        doneNxt     = txDone;
        pendDatNxt  = pendDat;
        pendSomNxt  = pendSom;
        pendEomNxt  = pendEom;
        pendAbrtNxt = pendAbrt;
        crcPreset   = 1'b0;
        crcEn       = 1'b0;
        crcBit      = 1'b0;
        taken       = 1'b0;

        nextIdx    = bitCnt + BITCNTW'(1);
        unitLast   = (state == CRC) ? (bitCnt == BITCNTW'(15)) : (bitCnt == BITCNTW'(7));
        stuffState = (state == DATA) || (state == CRC);
        stuffNow   = stuffState && (onesCnt == ONESW'(STUFFRUN));

        if (txCLKEN) begin
            if (stuffNow) begin
                // inserted zero; shift register and bit counter stall
                sdoNxt = 1'b0;
            end else if ((state == IDLE) || unitLast) begin
                bitCntNxt = '0;
                if (state == CRC) begin
                    // CRC is always followed by the closing flag
                    stateNxt = CLOSE;
                    shRegNxt = FLAGCHAR;
                    sdoNxt   = FLAGCHAR[0];
                end else if (!txENABLE) begin
                    stateNxt = IDLE;
                    sdoNxt   = 1'b1;
                end else if (!txDone) begin
                    taken = 1'b1;
                    if (pendAbrt) begin
                        stateNxt = ABORT;
                        shRegNxt = ABORTCHAR;
                        sdoNxt   = ABORTCHAR[0];
                    end else if (pendEom) begin
                        stateNxt = CRC;
                        sdoNxt   = ~crcOut[0];
                    end else if (pendSom) begin
                        stateNxt  = FLAG;
                        shRegNxt  = FLAGCHAR;
                        sdoNxt    = FLAGCHAR[0];
                        crcPreset = 1'b1;
                    end else begin
                        stateNxt = DATA;
                        shRegNxt = pendDat;
                        sdoNxt   = pendDat[0];
                        crcEn    = 1'b1;
                        crcBit   = pendDat[0];
                    end
                end else begin
                    case (state)
                        FLAG: begin
                            shRegNxt = FLAGCHAR;
                            sdoNxt   = FLAGCHAR[0];
                        end
                        DATA: begin
                            stateNxt = ABORT;
                            shRegNxt = ABORTCHAR;
                            sdoNxt   = ABORTCHAR[0];
                            underNxt = 1'b1;
                        end
                        default: begin
                            stateNxt = IDLE;
                            sdoNxt   = 1'b1;
                        end
                    endcase
                end
            end else begin
                bitCntNxt = nextIdx;
                if (state == CRC) begin
                    sdoNxt = ~crcOut[nextIdx];
                end else begin
                    shRegNxt = {1'b0, shReg[DATAW-1:1]};
                    sdoNxt   = shReg[1];
                end
                if (state == DATA) begin
                    crcEn  = 1'b1;
                    crcBit = shReg[1];
                end
            end

            // ones run only tracked while stuffing applies; a run carries DATA->CRC
            if (!stuffNow && ((stateNxt == DATA) || (stateNxt == CRC)) && sdoNxt) begin
                onesCntNxt = onesCnt + ONESW'(1);
            end else begin
                onesCntNxt = '0;
            end
        end

        if (taken) begin
            doneNxt = 1'b1;
        end
        if (txb.txLOAD) begin
            doneNxt     = 1'b0;
            pendDatNxt  = txb.dupTXDAT;
            pendSomNxt  = txb.dupTXSOM;
            pendEomNxt  = txb.dupTXEOM;
            pendAbrtNxt = txb.dupTXABRT;
        end

        activeNxt = (stateNxt != IDLE);
    end

    // State and datapath registers; dupINIT behaves as a synchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shReg    <= '0;
            bitCnt   <= '0;
            onesCnt  <= '0;
            txSDO    <= 1'b1;
            txUNDER  <= 1'b0;
            txACTIVE <= 1'b0;
            txDone   <= 1'b1;
            pendDat  <= '0;
            pendSom  <= 1'b0;
            pendEom  <= 1'b0;
            pendAbrt <= 1'b0;
        end else if (dupINIT) begin
            state    <= IDLE;
            shReg    <= '0;
            bitCnt   <= '0;
            onesCnt  <= '0;
            txSDO    <= 1'b1;
            txUNDER  <= 1'b0;
            txACTIVE <= 1'b0;
            txDone   <= 1'b1;
            pendDat  <= '0;
            pendSom  <= 1'b0;
            pendEom  <= 1'b0;
            pendAbrt <= 1'b0;
        end else begin
            state    <= stateNxt;
            shReg    <= shRegNxt;
            bitCnt   <= bitCntNxt;
            onesCnt  <= onesCntNxt;
            txSDO    <= sdoNxt;
            txUNDER  <= underNxt;
            txACTIVE <= activeNxt;
            txDone   <= doneNxt;
            pendDat  <= pendDatNxt;
            pendSom  <= pendSomNxt;
            pendEom  <= pendEomNxt;
            pendAbrt <= pendAbrtNxt;
        end
    end

endmodule

// File: tb/tb_dup_tx_serializer.sv
// Directed bench for dup_tx_serializer with hand-computed serial streams.
module tb_dup_tx_serializer;

    logic clk;
    logic rst;
    logic dupINIT;
    logic txENABLE;
    logic txCLKEN;
    logic txSDO;
    logic txACTIVE;
    logic txUNDER;

    int vecs = 0;
    int errs = 0;

    dup_tx_serializer_if txIf ();

    dup_tx_serializer dut (
        .clk      (clk),
        .rst      (rst),
        .dupINIT  (dupINIT),
        .txENABLE (txENABLE),
        .txCLKEN  (txCLKEN),
        .txb      (txIf),
        .txSDO    (txSDO),
        .txACTIVE (txACTIVE),
        .txUNDER  (txUNDER)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one txCLKEN pulse; returns the bit it selected
    task automatic bitClk(output logic b);
        txCLKEN = 1'b1;
        @(negedge clk);
        txCLKEN = 1'b0;
        b = txSDO;
    endtask

    task automatic loadChar(input logic [7:0] d, input logic som, input logic eom, input logic abrt);
        txIf.txLOAD    = 1'b1;
        txIf.dupTXDAT  = d;
        txIf.dupTXSOM  = som;
        txIf.dupTXEOM  = eom;
        txIf.dupTXABRT = abrt;
        @(negedge clk);
        txIf.txLOAD = 1'b0;
    endtask

    // n bit times collected LSB first; optional TXDBUF load right after the first bit
    // ld = {abrt, eom, som, data}
    task automatic unit(input int n, input logic doLoad, input logic [10:0] ld, output logic [15:0] v);
        logic b;
        v = '0;
        bitClk(b);
        v[0] = b;
        if (doLoad) loadChar(ld[7:0], ld[8], ld[9], ld[10]);
        for (int i = 1; i < n; i++) begin
            bitClk(b);
            v[i] = b;
        end
    endtask

    initial begin
        logic [15:0] v;
        logic        b;
        int          ones;

        rst            = 1'b1;
        dupINIT        = 1'b0;
        txENABLE       = 1'b1;
        txCLKEN        = 1'b0;
        txIf.txLOAD    = 1'b0;
        txIf.dupTXDAT  = 8'h00;
        txIf.dupTXSOM  = 1'b0;
        txIf.dupTXEOM  = 1'b0;
        txIf.dupTXABRT = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset state
        check("rst_done",   16'(txIf.dupTXDONE), 16'h1);
        check("rst_sdo",    16'(txSDO),          16'h1);
        check("rst_crc",    16'(txIf.dupTXCRC),  16'h1);
        check("rst_active", 16'(txACTIVE),       16'h0);
        check("rst_under",  16'(txUNDER),        16'h0);

        // idle mark over 20 bit times
        ones = 0;
        for (int i = 0; i < 20; i++) begin
            bitClk(b);
            ones += int'(b);
        end
        check("idle_ones",   16'(ones),     16'd20);
        check("idle_active", 16'(txACTIVE), 16'h0);

        // X-25 frame: SOM, "123456789", EOM
        loadChar(8'h00, 1'b1, 1'b0, 1'b0);
        check("som_done_clr", 16'(txIf.dupTXDONE), 16'h0);
        unit(8, 1'b1, {3'b000, 8'h31}, v);
        check("x25_open", v, 16'h007E);
        for (int k = 0; k < 9; k++) begin
            logic [10:0] ld;
            ld = (k < 8) ? {3'b000, 8'(8'h32 + k)} : {3'b010, 8'h00};
            unit(8, 1'b1, ld, v);
            check("x25_data", v, 16'(8'h31 + k));
        end
        unit(8, 1'b0, 11'h0, v);
        check("x25_crc_lo", v, 16'h006E);
        unit(8, 1'b0, 11'h0, v);
        check("x25_crc_hi", v, 16'h0090);
        unit(8, 1'b0, 11'h0, v);
        check("x25_close", v, 16'h007E);
        bitClk(b);
        check("x25_mark",   16'(b),              16'h1);
        check("x25_active", 16'(txACTIVE),       16'h0);
        check("x25_done",   16'(txIf.dupTXDONE), 16'h1);

        // FF data: one stuffed zero in data, one in the CRC high byte
        loadChar(8'h00, 1'b1, 1'b0, 1'b0);
        unit(8, 1'b1, {3'b000, 8'hFF}, v);
        check("ff_open", v, 16'h007E);
        unit(9, 1'b1, {3'b010, 8'h00}, v);
        check("ff_data_stuffed", v, 16'h01DF);
        unit(8, 1'b0, 11'h0, v);
        check("ff_crc_lo", v, 16'h0000);
        unit(9, 1'b0, 11'h0, v);
        check("ff_crc_hi_stuffed", v, 16'h01DF);
        unit(8, 1'b0, 11'h0, v);
        check("ff_close", v, 16'h007E);
        bitClk(b);
        check("ff_mark", 16'(b), 16'h1);

        // underrun after one data byte
        loadChar(8'h00, 1'b1, 1'b0, 1'b0);
        unit(8, 1'b1, {3'b000, 8'h55}, v);
        check("ur_open", v, 16'h007E);
        unit(8, 1'b0, 11'h0, v);
        check("ur_data", v, 16'h0055);
        bitClk(b);
        check("ur_abort_bit0", 16'(b),        16'h1);
        check("ur_under_hi",   16'(txUNDER),  16'h1);
        check("ur_active",     16'(txACTIVE), 16'h1);
        unit(7, 1'b0, 11'h0, v);
        check("ur_abort_rest", v, 16'h007F);
        check("ur_under_lo", 16'(txUNDER), 16'h0);
        bitClk(b);
        check("ur_mark",   16'(b),              16'h1);
        check("ur_idle",   16'(txACTIVE),       16'h0);
        check("ur_done",   16'(txIf.dupTXDONE), 16'h1);

        // repeated flags until data, then abort loaded mid-byte
        loadChar(8'h00, 1'b1, 1'b0, 1'b0);
        unit(8, 1'b0, 11'h0, v);
        check("rf_flag1", v, 16'h007E);
        unit(8, 1'b0, 11'h0, v);
        check("rf_flag2", v, 16'h007E);
        unit(8, 1'b1, {3'b000, 8'h0F}, v);
        check("rf_flag3", v, 16'h007E);
        unit(8, 1'b1, {3'b100, 8'h00}, v);
        check("ab_data", v, 16'h000F);
        unit(8, 1'b0, 11'h0, v);
        check("ab_unstuffed", v, 16'h00FF);
        check("ab_no_under", 16'(txUNDER), 16'h0);
        bitClk(b);
        check("ab_mark", 16'(b),        16'h1);
        check("ab_idle", 16'(txACTIVE), 16'h0);

        // dupINIT during CRC
        loadChar(8'h00, 1'b1, 1'b0, 1'b0);
        unit(8, 1'b1, {3'b000, 8'h01}, v);
        check("in_open", v, 16'h007E);
        unit(8, 1'b1, {3'b010, 8'h00}, v);
        check("in_data", v, 16'h0001);
        check("in_crc_bit0", 16'(txIf.dupTXCRC), 16'h0);
        unit(4, 1'b0, 11'h0, v);
        check("in_crc_nibble", v, 16'h0001);
        loadChar(8'h42, 1'b0, 1'b0, 1'b0);
        check("in_pending", 16'(txIf.dupTXDONE), 16'h0);
        dupINIT = 1'b1;
        @(negedge clk);
        dupINIT = 1'b0;
        check("in_sdo",    16'(txSDO),          16'h1);
        check("in_active", 16'(txACTIVE),       16'h0);
        check("in_crc",    16'(txIf.dupTXCRC),  16'h1);
        check("in_done",   16'(txIf.dupTXDONE), 16'h1);

        // load in the same clk as a take, then txENABLE dropped mid-flag
        loadChar(8'h00, 1'b1, 1'b0, 1'b0);
        txCLKEN        = 1'b1;
        txIf.txLOAD    = 1'b1;
        txIf.dupTXDAT  = 8'h00;
        txIf.dupTXSOM  = 1'b0;
        txIf.dupTXEOM  = 1'b0;
        txIf.dupTXABRT = 1'b0;
        @(negedge clk);
        txCLKEN     = 1'b0;
        txIf.txLOAD = 1'b0;
        check("lt_done", 16'(txIf.dupTXDONE), 16'h0);
        check("lt_bit0", 16'(txSDO),          16'h0);
        unit(3, 1'b0, 11'h0, v);
        check("lt_flag_mid", v, 16'h0007);
        txENABLE = 1'b0;
        unit(4, 1'b0, 11'h0, v);
        check("en_flag_tail", v, 16'h0007);
        bitClk(b);
        check("en_mark",     16'(b),              16'h1);
        check("en_idle",     16'(txACTIVE),       16'h0);
        check("en_retained", 16'(txIf.dupTXDONE), 16'h0);
        bitClk(b);
        check("en_hold", 16'(txIf.dupTXDONE), 16'h0);
        txENABLE = 1'b1;
        bitClk(b);
        check("en_data_bit0", 16'(b),              16'h0);
        check("en_taken",     16'(txIf.dupTXDONE), 16'h1);
        check("en_active",    16'(txACTIVE),       16'h1);
        dupINIT = 1'b1;
        @(negedge clk);
        dupINIT = 1'b0;
        check("end_idle", 16'(txACTIVE), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
